// File: rtl/bsg_buf_ctrl_strobe_gen.sv
// Programmable periodic strobe generator. A valid/ready command loads the
// period, the high time and the repetition count. While running, ctrl_o is
// high for the first `high` cycles of every `period`-cycle window. The run
// stops after `reps` periods, runs forever when reps is 0, and can be aborted
// with stop_i. ctrl_o feeds the buffer-control fanout stage directly.
module bsg_buf_ctrl_strobe_gen #(
    parameter int width_p = 16
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic [width_p-1:0] period_i,
    input  logic [width_p-1:0] high_i,
    input  logic [width_p-1:0] reps_i,
    input  logic               stop_i,
    output logic               ctrl_o,
    output logic               busy_o,
    output logic               done_o
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e             state_q, state_n;
    logic [width_p-1:0] cnt_q, cnt_n;
    logic [width_p-1:0] rcnt_q, rcnt_n;
    logic [width_p-1:0] period_q, period_n;
    logic [width_p-1:0] high_q, high_n;
    logic [width_p-1:0] reps_q, reps_n;
    logic               ctrl_q, ctrl_n;
    logic               busy_q, busy_n;
    logic               done_q, done_n;

    logic [width_p-1:0] period_m1;
    logic [width_p-1:0] reps_m1;
    logic               last_cnt;
    logic               last_rep;

    assign period_m1 = period_q - width_p'(1);
    assign reps_m1   = reps_q - width_p'(1);
    assign last_cnt  = (cnt_q == period_m1);
    // reps == 0 is free-run, so there is never a final repetition.
    assign last_rep  = (reps_q != '0) && (rcnt_q == reps_m1);

    // Commands are only taken while idle; no queuing.
    assign ready_o = (state_q == IDLE);
    assign ctrl_o  = ctrl_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

    // Next-state logic: command accept, phase/rep counting, completion and abort.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_n  = state_q;
        cnt_n    = cnt_q;
        rcnt_n   = rcnt_q;
        period_n = period_q;
        high_n   = high_q;
        reps_n   = reps_q;
        ctrl_n   = 1'b0;
        busy_n   = 1'b0;
        done_n   = 1'b0;

        case (state_q)
            IDLE: begin
                if (v_i) begin
                    period_n = period_i;
                    high_n   = high_i;
                    reps_n   = reps_i;
                    cnt_n    = '0;
                    rcnt_n   = '0;
                    if ((period_i == '0) || (high_i == '0)) begin
                        // Nothing to generate: report completion straight away.
                        done_n = 1'b1;
                    end else begin
                        state_n = RUN;
                        busy_n  = 1'b1;
                        ctrl_n  = 1'b1;  // phase 0 is always inside the high window
                    end
                end
            end
            RUN: begin
                if (stop_i) begin
                    // Abort wins over counting; a stop on the final cycle still
                    // produces just this one done pulse.
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else if (last_cnt && last_rep) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    busy_n = 1'b1;
                    if (last_cnt) begin
                        cnt_n  = '0;
                        rcnt_n = rcnt_q + width_p'(1);
                    end else begin
                        cnt_n = cnt_q + width_p'(1);
                    end
                    // high >= period keeps this true for every phase: no low gap.
                    ctrl_n = (cnt_n < high_q);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, counters, latched fields and registered outputs.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            // NOTE: reset clears every register, including the latched command fields.
            state_q  <= IDLE;
            cnt_q    <= '0;
            rcnt_q   <= '0;
            period_q <= '0;
            high_q   <= '0;
            reps_q   <= '0;
            ctrl_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so all registers move together on the edge.
            state_q  <= state_n;
            cnt_q    <= cnt_n;
            rcnt_q   <= rcnt_n;
            period_q <= period_n;
            high_q   <= high_n;
            reps_q   <= reps_n;
            ctrl_q   <= ctrl_n;
            busy_q   <= busy_n;
            done_q   <= done_n;
        end
    end

endmodule

// File: tb/tb_bsg_buf_ctrl_strobe_gen.sv
// Self-checking bench for bsg_buf_ctrl_strobe_gen. A cycle-level reference
// model describes each run as "cycle k of the run is high when k mod period <
// high, and the run lasts reps*period cycles", and is compared against the
// DUT every cycle under directed and random command streams.
module tb_bsg_buf_ctrl_strobe_gen;

    localparam int W = 16;

    logic         clk_i;
    logic         reset_n_i;
    logic         v_i;
    logic         ready_o;
    logic [W-1:0] period_i;
    logic [W-1:0] high_i;
    logic [W-1:0] reps_i;
    logic         stop_i;
    logic         ctrl_o;
    logic         busy_o;
    logic         done_o;

    bsg_buf_ctrl_strobe_gen #(.width_p(W)) dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_i       (v_i),
        .ready_o   (ready_o),
        .period_i  (period_i),
        .high_i    (high_i),
        .reps_i    (reps_i),
        .stop_i    (stop_i),
        .ctrl_o    (ctrl_o),
        .busy_o    (busy_o),
        .done_o    (done_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: is a run active, which cycle of it comes next, and the
    // command that started it.
    bit          m_run;
    longint      m_k;
    longint      m_p, m_h, m_r;
    logic        exp_ctrl, exp_busy, exp_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".ctrl"},  32'(ctrl_o),  32'(exp_ctrl));
        check({tag, ".busy"},  32'(busy_o),  32'(exp_busy));
        check({tag, ".done"},  32'(done_o),  32'(exp_done));
        check({tag, ".ready"}, 32'(ready_o), 32'(!m_run));
    endtask

    // Advance the model over the coming clock edge, given the inputs driven now.
    task automatic model_step();
        exp_ctrl = 1'b0;
        exp_busy = 1'b0;
        exp_done = 1'b0;
        if (!m_run) begin
            if (v_i) begin
                if (period_i == 0 || high_i == 0) begin
                    exp_done = 1'b1;
                end else begin
                    m_run = 1'b1;
                    m_k   = 0;
                    m_p   = longint'(period_i);
                    m_h   = longint'(high_i);
                    m_r   = longint'(reps_i);
                    exp_busy = 1'b1;
                    exp_ctrl = 1'b1;
                end
            end
        end else if (stop_i) begin
            m_run    = 1'b0;
            exp_done = 1'b1;
        end else if (m_r != 0 && m_k + 1 == m_r * m_p) begin
            m_run    = 1'b0;
            exp_done = 1'b1;
        end else begin
            m_k++;
            exp_busy = 1'b1;
            exp_ctrl = ((m_k % m_p) < m_h);
        end
    endtask

    // Called at a falling edge: check this cycle, drive the next inputs,
    // step the model and move to the next falling edge.
    task automatic cycle(input string tag, input logic v, input logic stop,
                         input int p, input int h, input int r);
        check_outputs(tag);
        v_i      = v;
        stop_i   = stop;
        period_i = W'(p);
        high_i   = W'(h);
        reps_i   = W'(r);
        model_step();
        @(negedge clk_i);
    endtask

    task automatic idle_cycles(input string tag, input int n);
        for (int i = 0; i < n; i++) cycle(tag, 1'b0, 1'b0, 0, 0, 0);
    endtask

    // Asynchronous reset between edges: outputs must drop before the next edge.
    task automatic mid_cycle_reset();
        v_i    = 1'b0;
        stop_i = 1'b0;
        #2 reset_n_i = 1'b0;
        #1;
        check("async_rst.ctrl",  32'(ctrl_o),  32'd0);
        check("async_rst.busy",  32'(busy_o),  32'd0);
        check("async_rst.done",  32'(done_o),  32'd0);
        check("async_rst.ready", 32'(ready_o), 32'd1);
        m_run    = 1'b0;
        exp_ctrl = 1'b0;
        exp_busy = 1'b0;
        exp_done = 1'b0;
        @(negedge clk_i);
        reset_n_i = 1'b1;
    endtask

    initial begin
        int p, h, r;
        reset_n_i = 1'b0;
        v_i = 1'b0; stop_i = 1'b0;
        period_i = '0; high_i = '0; reps_i = '0;
        m_run = 1'b0; m_k = 0; m_p = 0; m_h = 0; m_r = 0;
        exp_ctrl = 1'b0; exp_busy = 1'b0; exp_done = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        check_outputs("reset");
        reset_n_i = 1'b1;
        @(negedge clk_i);

        // Mid-run reset of a free-running strobe: no done pulse afterwards.
        cycle("fr8", 1'b1, 1'b0, 8, 4, 0);
        idle_cycles("fr8", 6);
        mid_cycle_reset();
        idle_cycles("post_rst", 4);

        // period 4, high 1, reps 2: 1,0,0,0,1,0,0,0 then done.
        cycle("p4h1r2", 1'b1, 1'b0, 4, 1, 2);
        idle_cycles("p4h1r2", 10);

        // high above period: solid high for 3 cycles, then done.
        cycle("p3h5r1", 1'b1, 1'b0, 3, 5, 1);
        idle_cycles("p3h5r1", 5);

        // Degenerate commands.
        cycle("p0", 1'b1, 1'b0, 0, 2, 3);
        idle_cycles("p0", 3);
        cycle("h0", 1'b1, 1'b0, 6, 0, 1);
        idle_cycles("h0", 3);

        // Free-run with v_i held during RUN and stop_i in cycle 12.
        cycle("fr5", 1'b1, 1'b0, 5, 2, 0);
        for (int i = 1; i <= 11; i++) cycle("fr5", 1'b1, 1'b0, 3, 1, 1);
        cycle("fr5", 1'b1, 1'b1, 3, 1, 1);
        idle_cycles("fr5", 3);

        // Stop on the natural final cycle: a single done pulse.
        cycle("stop_last", 1'b1, 1'b0, 2, 1, 1);
        cycle("stop_last", 1'b0, 1'b0, 0, 0, 0);
        cycle("stop_last", 1'b0, 1'b1, 0, 0, 0);
        idle_cycles("stop_last", 3);

        // Back-to-back: second command waits and is taken in the done cycle.
        cycle("b2b", 1'b1, 1'b0, 2, 1, 1);
        for (int i = 1; i <= 3; i++) cycle("b2b", 1'b1, 1'b0, 2, 2, 1);
        idle_cycles("b2b", 4);

        // Maximum period with high at the same value.
        cycle("pmax", 1'b1, 1'b0, 65535, 65535, 0);
        idle_cycles("pmax", 20);
        cycle("pmax", 1'b0, 1'b1, 0, 0, 0);
        idle_cycles("pmax", 2);

        // Random command stream.
        for (int i = 0; i < 4000; i++) begin
            p = $urandom_range(0, 9);
            h = $urandom_range(0, 12);
            r = $urandom_range(0, 4);
            if ($urandom_range(0, 19) == 0) begin
                p = $urandom_range(60000, 65535);
                h = $urandom_range(0, 65535);
            end
            cycle("rand", ($urandom_range(0, 2) == 0), ($urandom_range(0, 39) == 0), p, h, r);
            if ($urandom_range(0, 999) == 0) mid_cycle_reset();
        end
        idle_cycles("tail", 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard time limit so the bench always terminates.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got %0d checks, expected completion", n_checks);
        $fatal(1, "timeout");
    end

endmodule
